// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state codes and instruction layout for the bit-serial ALU issue stage.
package alu_seq_pkg;

  localparam logic [2:0] OP_RESET = 3'b000;
  localparam logic [2:0] OP_NAND  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_LOGIC = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam int unsigned SERIAL_BITS = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } alu_instr_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_ADD) || (op == OP_LOGIC) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Upstream handshake, ALU drive/return and result signals of the issue stage.
interface alu_seq_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_c;
  logic       alu_zf;
  logic       alu_sf;
  logic       alu_cf;

  logic       res_valid;
  logic [3:0] res_c;
  logic [2:0] res_op;
  logic       res_zf;
  logic       res_sf;
  logic       res_cf;
  logic       err_illegal;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_c, alu_zf, alu_sf, alu_cf,
    output in_ready, alu_a, alu_b, alu_opcode,
    output res_valid, res_c, res_op, res_zf, res_sf, res_cf, err_illegal
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_c, alu_zf, alu_sf, alu_cf,
    input  in_ready, alu_a, alu_b, alu_opcode,
    input  res_valid, res_c, res_op, res_zf, res_sf, res_cf, err_illegal
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap freely.
module alu_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0] CntOne  = {{PtrW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage: queues operations, drives each into the bit-serial ALU for SERIAL_BITS clocks,
// then captures the result and flags; the ALU is parked on OP_RESET between operations.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned BitW = $clog2(SERIAL_BITS);
  localparam logic [BitW-1:0] LastBit = BitW'(SERIAL_BITS - 1);

  alu_instr_t      in_instr, fifo_rdata, ir_q, ir_d;
  logic            ready, accept, legal, push, pop, capture, full, empty;
  logic [CntW-1:0] count;
  logic [1:0]      state_q, state_d;
  logic [BitW-1:0] bitcnt_q, bitcnt_d;

  logic       res_valid_q, res_zf_q, res_sf_q, res_cf_q, err_q;
  logic [3:0] res_c_q;
  logic [2:0] res_op_q;

  assign in_instr = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  assign ready    = (count != CntW'(DEPTH));
  assign accept   = bus.in_valid && ready;
  assign legal    = is_legal_op(bus.in_op);
  // Illegal opcodes still complete the handshake but never occupy a slot.
  assign push     = bus.in_valid && !full && legal;

  alu_seq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(alu_instr_t))
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .wdata_i(in_instr),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  // empty reflects pre-edge occupancy, so a same-edge push is never bypassed into the IR.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    ir_d     = ir_q;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          ir_d     = fifo_rdata;
          bitcnt_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LastBit) state_d = S_CAPT;
      end
      S_CAPT: begin
        capture = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          ir_d     = fifo_rdata;
          bitcnt_d = '0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      ir_q        <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_op_q    <= OP_RESET;
      res_zf_q    <= 1'b0;
      res_sf_q    <= 1'b0;
      res_cf_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      ir_q        <= ir_d;
      res_valid_q <= capture;
      err_q       <= accept && !legal;
      if (capture) begin
        res_c_q  <= bus.alu_c;
        res_op_q <= ir_q.op;
        res_zf_q <= bus.alu_zf;
        res_sf_q <= bus.alu_sf;
        res_cf_q <= bus.alu_cf;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.alu_a       = ir_q.a;
  assign bus.alu_b       = ir_q.b;
  assign bus.alu_opcode  = (state_q == S_RUN) ? ir_q.op : OP_RESET;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_c       = res_c_q;
  assign bus.res_op      = res_op_q;
  assign bus.res_zf      = res_zf_q;
  assign bus.res_sf      = res_sf_q;
  assign bus.res_cf      = res_cf_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: serial ALU stand-in, schedule-based reference model, per-cycle compare.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if bus ();

  alu_op_sequencer #(.DEPTH(Depth)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Bit-serial ALU stand-in: one result bit per clock, cleared whenever opcode 000 is seen.
  logic [1:0] alu_cnt   = 2'd0;
  logic [3:0] alu_acc   = 4'd0;
  logic       alu_carry = 1'b0;
  logic       abit, bbit;
  assign abit = bus.alu_a[alu_cnt];
  assign bbit = bus.alu_b[alu_cnt];
  assign bus.alu_c  = alu_acc;
  assign bus.alu_zf = (alu_acc == 4'd0);
  assign bus.alu_sf = alu_acc[3];
  assign bus.alu_cf = alu_carry;

  always @(posedge clk) begin
    if (bus.alu_opcode == OP_RESET) begin
      alu_cnt   <= 2'd0;
      alu_acc   <= 4'd0;
      alu_carry <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 2'd1;
      case (bus.alu_opcode)
        OP_ADD: begin
          alu_acc[alu_cnt] <= abit ^ bbit ^ alu_carry;
          alu_carry        <= (abit & bbit) | (alu_carry & (abit ^ bbit));
        end
        OP_SUB: begin
          alu_acc[alu_cnt] <= abit ^ bbit ^ alu_carry;
          alu_carry        <= (~abit & bbit) | (~(abit ^ bbit) & alu_carry);
        end
        OP_NAND: alu_acc[alu_cnt] <= ~(abit & bbit);
        default: alu_acc[alu_cnt] <= abit ^ bbit;
      endcase
    end
  end

  // Reference model: each legal op gets a pop edge and a capture edge five edges later.
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    int         pop_e;
    int         capt_e;
  } mop_t;

  mop_t pend[$];
  int   cur_e = 0;
  int   prev_capt = 0;
  bit   model_on = 1'b0;
  int   acc_n = 0;

  logic       m_rv, m_zf, m_sf, m_cf, m_err;
  logic [3:0] m_c, m_a, m_b;
  logic [2:0] m_op;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_n = 0, obs_edge = 0, err_n = 0;
  logic [3:0] obs_c;
  logic [2:0] obs_op;
  logic       obs_zf, obs_sf, obs_cf;
  bit         saw_full = 1'b0;

  function automatic logic [6:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    logic [4:0] w;
    logic [3:0] c;
    logic       cf;
    case (op)
      3'b010: begin w = {1'b0, a} + {1'b0, b}; c = w[3:0]; cf = w[4]; end
      3'b100: begin w = {1'b0, a} - {1'b0, b}; c = w[3:0]; cf = w[4]; end
      3'b001: begin c = ~(a & b); cf = 1'b0; end
      default: begin c = a ^ b; cf = 1'b0; end
    endcase
    return {c, (c == 4'd0), c[3], cf};
  endfunction

  function automatic bit legal_op(input logic [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011, 3'b100};
  endfunction

  function automatic int occupancy();
    int n = 0;
    foreach (pend[i]) if (pend[i].pop_e > cur_e) n++;
    return n;
  endfunction

  function automatic logic [2:0] exp_opcode();
    foreach (pend[i]) begin
      if (cur_e >= pend[i].pop_e && cur_e <= pend[i].pop_e + 3) return pend[i].op;
    end
    return 3'b000;
  endfunction

  task automatic model_edge(input bit rdy);
    bit         acc;
    logic [6:0] r;
    mop_t       n;
    cur_e++;
    if (rst) begin
      pend.delete();
      prev_capt = 0;
      {m_rv, m_zf, m_sf, m_cf, m_err} = 5'b0;
      m_c = 4'd0; m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
      model_on = 1'b1;
      return;
    end
    acc   = bus.in_valid && rdy;
    m_err = acc && !legal_op(bus.in_op);
    m_rv  = 1'b0;
    if (pend.size() > 0 && pend[0].capt_e == cur_e) begin
      r = ref_alu(pend[0].a, pend[0].b, pend[0].op);
      {m_c, m_zf, m_sf, m_cf} = r;
      m_op = pend[0].op;
      m_rv = 1'b1;
      void'(pend.pop_front());
    end
    foreach (pend[i]) if (pend[i].pop_e == cur_e) begin m_a = pend[i].a; m_b = pend[i].b; end
    if (acc && legal_op(bus.in_op)) begin
      n.a = bus.in_a; n.b = bus.in_b; n.op = bus.in_op;
      n.pop_e  = (cur_e + 1 > prev_capt) ? cur_e + 1 : prev_capt;
      n.capt_e = n.pop_e + 5;
      prev_capt = n.capt_e;
      pend.push_back(n);
      acc_n++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cur_e);
    end
  endtask

  task automatic compare();
    if (!model_on) return;
    chk("in_ready", int'(bus.in_ready), int'(occupancy() < int'(Depth)));
    chk("res_valid", int'(bus.res_valid), int'(m_rv));
    chk("res_c", int'(bus.res_c), int'(m_c));
    chk("res_op", int'(bus.res_op), int'(m_op));
    chk("res_zf", int'(bus.res_zf), int'(m_zf));
    chk("res_sf", int'(bus.res_sf), int'(m_sf));
    chk("res_cf", int'(bus.res_cf), int'(m_cf));
    chk("err_illegal", int'(bus.err_illegal), int'(m_err));
    chk("alu_opcode", int'(bus.alu_opcode), int'(exp_opcode()));
    chk("alu_a", int'(bus.alu_a), int'(m_a));
    chk("alu_b", int'(bus.alu_b), int'(m_b));
    if (bus.res_valid) begin
      obs_n++;
      obs_edge = cur_e;
      obs_c = bus.res_c; obs_op = bus.res_op;
      obs_zf = bus.res_zf; obs_sf = bus.res_sf; obs_cf = bus.res_cf;
    end
    if (bus.err_illegal) err_n++;
    if (!bus.in_ready) saw_full = 1'b1;
  endtask

  task automatic tick();
    bit rdy;
    rdy = (occupancy() < int'(Depth));
    @(posedge clk);
    model_edge(rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input bit v, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
    bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_op = op;
  endtask

  task automatic wait_result(input int bound, output bit got);
    int start;
    start = obs_n;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (obs_n != start) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    int e0, e1, n0, a0, k0;
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_opcode", int'(bus.alu_opcode), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);

    // ADD with carry: 7 + 9 wraps to 0
    set_in(1'b1, 4'd7, 4'd9, OP_ADD); tick(); e0 = cur_e;
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    wait_result(12, got);
    chk("add_seen", int'(got), 1);
    chk("add_latency", obs_edge - e0, 6);
    chk("add_c", int'(obs_c), 0);
    chk("add_zf", int'(obs_zf), 1);
    chk("add_sf", int'(obs_sf), 0);
    chk("add_cf", int'(obs_cf), 1);
    chk("add_op", int'(obs_op), 2);

    // SUB with borrow: 3 - 5
    set_in(1'b1, 4'd3, 4'd5, OP_SUB); tick();
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    wait_result(12, got);
    chk("sub_seen", int'(got), 1);
    chk("sub_c", int'(obs_c), 14);
    chk("sub_sf", int'(obs_sf), 1);
    chk("sub_zf", int'(obs_zf), 0);
    chk("sub_cf", int'(obs_cf), 1);

    // NAND then ADD back to back
    set_in(1'b1, 4'hF, 4'hF, OP_NAND); tick();
    set_in(1'b1, 4'd1, 4'd2, OP_ADD); tick();
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    wait_result(12, got);
    e1 = obs_edge;
    chk("nand_seen", int'(got), 1);
    chk("nand_c", int'(obs_c), 0);
    chk("nand_zf", int'(obs_zf), 1);
    chk("nand_cf", int'(obs_cf), 0);
    wait_result(12, got);
    chk("b2b_seen", int'(got), 1);
    chk("b2b_c", int'(obs_c), 3);
    chk("b2b_cf", int'(obs_cf), 0);
    chk("b2b_gap", obs_edge - e1, 5);

    // Hold in_valid until the FIFO saturates
    saw_full = 1'b0; n0 = obs_n; a0 = acc_n;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 4'(i), 4'd1, OP_ADD); tick();
    end
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    repeat (60) tick();
    chk("full_seen", int'(saw_full), 1);
    chk("full_no_loss", obs_n - n0, acc_n - a0);

    // Illegal opcodes
    k0 = err_n; n0 = obs_n;
    set_in(1'b1, 4'd5, 4'd5, 3'b110); tick();
    set_in(1'b1, 4'd5, 4'd5, 3'b000); tick();
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    repeat (8) tick();
    chk("illegal_pulses", err_n - k0, 2);
    chk("illegal_no_res", obs_n - n0, 0);

    // Reset in the second RUN cycle with two entries queued
    set_in(1'b1, 4'd1, 4'd1, OP_ADD); tick();
    set_in(1'b1, 4'd2, 4'd2, OP_ADD); tick();
    set_in(1'b1, 4'd3, 4'd3, OP_ADD); tick();
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    n0 = obs_n;
    repeat (10) tick();
    chk("midrst_no_res", obs_n - n0, 0);
    chk("midrst_opcode", int'(bus.alu_opcode), 0);
    chk("midrst_ready", int'(bus.in_ready), 1);
    set_in(1'b1, 4'd2, 4'd2, OP_ADD); tick();
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    wait_result(12, got);
    chk("midrst_add_seen", int'(got), 1);
    chk("midrst_add_c", int'(obs_c), 4);

    // Randomized traffic with varying density and occasional resets
    begin
      int dens;
      dens = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) dens = int'($urandom_range(10, 100));
        rst = ($urandom_range(0, 399) == 0);
        set_in(($urandom_range(0, 99) < dens), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        tick();
      end
    end
    rst = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 3'd0);
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
